// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: datapath width,
// zero word and fetch FSM encoding.
package inst_fetch_pkg;

   localparam int DW = 32;
   localparam logic [DW-1:0] ZERO = '0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2,
      ERR   = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/inst_fetch_pc_next.sv
// Stateless next-PC selection: redirect target, sequential advance, or hold.
module pc_next_gen #(
   parameter int DW = 32
) (
   input  logic [DW-1:0] pc,
   input  logic          advance,
   input  logic          redirect,
   input  logic [DW-1:0] redirect_pc,
   output logic [DW-1:0] next_pc
);

   always_comb begin
      next_pc = pc;
      if (redirect)
         next_pc = redirect_pc;
      else if (advance)
         next_pc = pc + DW'(4);
   end

endmodule

// File: rtl/inst_fetch.sv
// Single-issue instruction fetch: one word per cycle from a 1-cycle memory,
// with stall hold, one-cycle flush on redirect and a sticky misalignment trap.
module inst_fetch #(
   parameter int              DW       = inst_fetch_pkg::DW,
   parameter int              AW       = 5,
   parameter logic [DW-1:0]   RESET_PC = DW'(32'h0000_0000)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          stall_i,
   input  logic          redirect_i,
   input  logic [DW-1:0] redirect_pc_i,
   output logic [AW-1:0] mem_addr_o,
   output logic          mem_rd_en_o,
   input  logic [DW-1:0] mem_data_i,
   output logic [DW-1:0] inst_o,
   output logic [DW-1:0] inst_pc_o,
   output logic          inst_valid_o,
   output logic          fetch_err_o
);

   import inst_fetch_pkg::*;

   fetch_state_t  state_p0;
   logic [DW-1:0] pc_p0;
   logic [DW-1:0] pc_next;
   logic [DW-1:0] inst_p1;
   logic [DW-1:0] inst_pc_p1;
   logic          vld_p1;
   logic          err_p1;
   logic          active;
   logic          advance;
   logic          redir_live;
   logic          redir_bad;

   always_comb begin
      active     = (state_p0 == FETCH) || (state_p0 == FLUSH);
      advance    = (state_p0 == FETCH) && !stall_i;
      redir_live = active && redirect_i;
      redir_bad  = redirect_pc_i[1:0] != 2'b00;
   end

   pc_next_gen #(.DW(DW)) u_pc_next (
      .pc          (pc_p0),
      .advance     (advance),
      .redirect    (redir_live),
      .redirect_pc (redirect_pc_i),
      .next_pc     (pc_next)
   );

   // p0: address issue toward instruction memory
   assign mem_rd_en_o = rst_i && active;
   assign mem_addr_o  = rst_i ? pc_p0[AW+1:2] : '0;

   // p1: capture of the returned word alongside its PC
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_p0   <= IDLE;
         pc_p0      <= RESET_PC;
         inst_p1    <= DW'(ZERO);
         inst_pc_p1 <= DW'(ZERO);
         vld_p1     <= 1'b0;
         err_p1     <= 1'b0;
      end else begin
         case (state_p0)
            IDLE: state_p0 <= FETCH;
            FETCH, FLUSH: begin
               if (redirect_i) begin
                  vld_p1 <= 1'b0;
                  if (redir_bad) begin
                     state_p0 <= ERR;
                     err_p1   <= 1'b1;
                  end else begin
                     state_p0 <= FLUSH;
                     pc_p0    <= pc_next;
                  end
               end else if (state_p0 == FLUSH) begin
                  // target address was presented this cycle; capture starts next edge
                  state_p0 <= FETCH;
               end else if (!stall_i) begin
                  inst_p1    <= mem_data_i;
                  inst_pc_p1 <= pc_p0;
                  vld_p1     <= 1'b1;
                  pc_p0      <= pc_next;
               end
            end
            ERR: state_p0 <= ERR;
            default: state_p0 <= IDLE;
         endcase
      end
   end

   assign inst_o       = inst_p1;
   assign inst_pc_o    = inst_pc_p1;
   assign inst_valid_o = vld_p1;
   assign fetch_err_o  = err_p1;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios followed by random
// stall/redirect/reset traffic, compared against a transaction-level model.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redir;
   logic [31:0] redir_pc;
   logic [4:0]  mem_addr;
   logic        mem_rd_en;
   logic [31:0] mem_data;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        fetch_err;

   logic [31:0] mem [32];

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   bit          started;
   bit          dead;
   int          flush_left;
   logic [31:0] m_pc, m_inst, m_ipc;
   bit          m_vld, m_err;

   always #5 clk = ~clk;

   assign mem_data = mem[mem_addr];

   inst_fetch dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .stall_i       (stall),
      .redirect_i    (redir),
      .redirect_pc_i (redir_pc),
      .mem_addr_o    (mem_addr),
      .mem_rd_en_o   (mem_rd_en),
      .mem_data_i    (mem_data),
      .inst_o        (inst),
      .inst_pc_o     (inst_pc),
      .inst_valid_o  (inst_valid),
      .fetch_err_o   (fetch_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input bit s, input bit rd, input logic [31:0] rpc);
      if (!r) begin
         started = 0; dead = 0; flush_left = 0;
         m_pc = 32'h0; m_inst = 32'h0; m_ipc = 32'h0; m_vld = 0; m_err = 0;
      end else if (!started) begin
         started = 1;
      end else if (dead) begin
         // trapped until reset
      end else if (rd) begin
         m_vld = 0;
         if (rpc % 4 != 0) begin
            dead = 1; m_err = 1;
         end else begin
            m_pc = rpc; flush_left = 1;
         end
      end else if (flush_left > 0) begin
         flush_left--;
      end else if (!s) begin
         m_inst = mem[(m_pc / 4) % 32];
         m_ipc  = m_pc;
         m_vld  = 1;
         m_pc   = m_pc + 32'd4;
      end
   endtask

   task automatic cycle(input bit r, input bit s, input bit rd, input logic [31:0] rpc);
      @(negedge clk);
      rst = r; stall = s; redir = rd; redir_pc = rpc;
      #1;
      chk("mem_rd_en", {31'b0, mem_rd_en}, {31'b0, r && started && !dead});
      chk("mem_addr", {27'b0, mem_addr}, r ? {27'b0, m_pc[6:2]} : 32'h0);
      @(posedge clk);
      model_edge(r, s, rd, rpc);
      #1;
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_vld});
      chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
      chk("inst", inst, m_inst);
      chk("inst_pc", inst_pc, m_ipc);
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; redir = 1'b0; redir_pc = 32'h0;
      started = 0; dead = 0; flush_left = 0;
      m_pc = 0; m_inst = 0; m_ipc = 0; m_vld = 0; m_err = 0;
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      for (int i = 0; i < 4; i++) mem[i] = 32'hA000_0000 + i;

      // reset, release, free-run A0..A1
      repeat (2) cycle(0, 0, 0, 0);
      repeat (3) cycle(1, 0, 0, 0);
      chk("inst_A1", inst, 32'hA000_0001);
      // stall holding A1, then A2 on release
      repeat (3) cycle(1, 1, 0, 0);
      chk("stall_addr", {27'b0, mem_addr}, 32'd2);
      cycle(1, 0, 0, 0);
      chk("inst_A2", inst, 32'hA000_0002);
      // redirect under stall
      cycle(1, 1, 0, 0);
      cycle(1, 1, 1, 32'h14);
      repeat (2) cycle(1, 0, 0, 0);
      chk("redir_pc14", inst_pc, 32'h14);
      cycle(1, 0, 0, 0);
      // redirect near top of memory, wrap
      cycle(1, 0, 1, 32'h7C);
      repeat (3) cycle(1, 0, 0, 0);
      chk("wrap_pc", inst_pc, 32'h80);
      chk("wrap_inst", inst, 32'hA000_0000);
      // reset during flush
      cycle(1, 0, 1, 32'h20);
      cycle(0, 0, 0, 0);
      repeat (3) cycle(1, 0, 0, 0);
      // misaligned redirect, then ignored redirect, then reset
      cycle(1, 0, 1, 32'h06);
      cycle(1, 0, 1, 32'h10);
      cycle(1, 1, 0, 0);
      chk("err_sticky", {31'b0, fetch_err}, 32'd1);
      cycle(0, 0, 0, 0);
      repeat (3) cycle(1, 0, 0, 0);

      // random traffic
      for (int n = 0; n < 500; n++) begin
         bit r, s, rd;
         logic [31:0] t;
         r  = ($urandom_range(0, 49) != 0) && !(dead && $urandom_range(0, 7) == 0);
         s  = ($urandom_range(0, 9) < 3);
         rd = ($urandom_range(0, 9) == 0);
         t  = $urandom;
         if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
         cycle(r, s, rd, t);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
